// File: rtl/fe_gshare_bpred.sv
// ---------------------------------------------------------------------------
// fe_gshare_bpred
//   Gshare direction predictor plus a direct-mapped BTB for the fetch stage.
//   Lookup is purely combinational on lk_pc.
//
//   Global history is shifted speculatively on every consumed BTB hit. It is
//   repaired from the echoed snapshot when a branch resolves as mispredicted.
//
//   After reset, an init sequencer walks the PHT, writing PHT_INIT into every
//   entry and clearing the BTB valid bits. ready is held low until that walk
//   is complete.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   ready             init sequence finished, predictions are live
//   lk_valid, lk_pc   fetch lookup (lk_valid = prediction consumed this cycle)
//   pred_taken        predicted taken
//   pred_target       predicted next PC
//   pred_idx          PHT index used for this lookup, echoed back later
//   pred_hist         history snapshot taken before this lookup
//   up_*              resolved-branch training port from AGEX
// ---------------------------------------------------------------------------
module fe_gshare_bpred #(
    parameter int         DBITS     = 32,
    parameter int         PHT_BITS  = 8,
    parameter int         HIST_BITS = 8,
    parameter int         BTB_BITS  = 4,
    parameter logic [1:0] PHT_INIT  = 2'b01
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 ready,
    input  logic                 lk_valid,
    input  logic [DBITS-1:0]     lk_pc,
    output logic                 pred_taken,
    output logic [DBITS-1:0]     pred_target,
    output logic [PHT_BITS-1:0]  pred_idx,
    output logic [HIST_BITS-1:0] pred_hist,
    input  logic                 up_valid,
    input  logic                 up_taken,
    input  logic                 up_mispred,
    input  logic [DBITS-1:0]     up_pc,
    input  logic [DBITS-1:0]     up_target,
    input  logic [PHT_BITS-1:0]  up_idx,
    input  logic [HIST_BITS-1:0] up_hist
);

    localparam int PHT_ENTRIES = 1 << PHT_BITS;
    localparam int BTB_ENTRIES = 1 << BTB_BITS;
    localparam int TAG_BITS    = DBITS - BTB_BITS - 2;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                 state_reg;
    logic [PHT_BITS-1:0]    init_cnt_reg;
    logic [HIST_BITS-1:0]   spec_hist_reg;
    logic [HIST_BITS-1:0]   spec_hist_next;

    logic [1:0]             pht_mem [PHT_ENTRIES];
    logic [BTB_ENTRIES-1:0] btb_valid_reg;
    logic [TAG_BITS-1:0]    btb_tag_mem [BTB_ENTRIES];
    logic [DBITS-1:0]       btb_target_mem [BTB_ENTRIES];

    logic                   running;
    logic [PHT_BITS-1:0]    hist_ext;
    logic [PHT_BITS-1:0]    lk_idx;
    logic [BTB_BITS-1:0]    lk_btb_idx;
    logic [TAG_BITS-1:0]    lk_tag;
    logic                   lk_hit;
    logic                   lk_taken;
    logic [DBITS-1:0]       pc_plus4;

    logic [BTB_BITS-1:0]    up_btb_idx;
    logic [TAG_BITS-1:0]    up_tag;
    logic [1:0]             up_cnt;
    logic [1:0]             up_cnt_next;
    logic                   btb_wr_en;
    logic [BTB_ENTRIES-1:0] btb_clr;
    logic [BTB_ENTRIES-1:0] btb_set;

    // The byte-offset bits of up_pc carry no information for a word-aligned branch.
    logic                   unused_up_pc_lsb;
    assign unused_up_pc_lsb = ^up_pc[1:0];

    assign running = (state_reg == ST_RUN);
    assign ready   = running;

    // ---------------------------------------------------------------------
    // Lookup
    // ---------------------------------------------------------------------
    always_comb begin
        hist_ext                  = '0;
        hist_ext[HIST_BITS-1:0]   = spec_hist_reg;
    end

    assign lk_idx     = lk_pc[PHT_BITS+1:2] ^ hist_ext;
    assign lk_btb_idx = lk_pc[BTB_BITS+1:2];
    assign lk_tag     = lk_pc[DBITS-1:BTB_BITS+2];
    assign pc_plus4   = lk_pc + DBITS'(4);

    // Gating by running is what makes the uninitialised BTB harmless during INIT.
    assign lk_hit      = running && btb_valid_reg[lk_btb_idx] && (btb_tag_mem[lk_btb_idx] == lk_tag);
    assign lk_taken    = lk_hit && pht_mem[lk_idx][1];
    assign pred_taken  = lk_taken;
    assign pred_target = lk_taken ? btb_target_mem[lk_btb_idx] : pc_plus4;
    assign pred_idx    = lk_idx;
    assign pred_hist   = spec_hist_reg;

    // ---------------------------------------------------------------------
    // Speculative history: a mispredict repair overrides a same-cycle shift
    // ---------------------------------------------------------------------
    always_comb begin
        spec_hist_next = spec_hist_reg;
        if (up_valid && up_mispred) begin
            spec_hist_next = {up_hist[HIST_BITS-2:0], up_taken};
        end else if (lk_valid && lk_hit) begin
            spec_hist_next = {spec_hist_reg[HIST_BITS-2:0], lk_taken};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_INIT;
            init_cnt_reg  <= '0;
            spec_hist_reg <= '0;
        end else begin
            case (state_reg)
                ST_INIT: begin
                    init_cnt_reg <= init_cnt_reg + 1'b1;
                    if (init_cnt_reg == {PHT_BITS{1'b1}}) begin
                        state_reg <= ST_RUN;
                    end
                end
                default: begin
                    spec_hist_reg <= spec_hist_next;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // PHT: one write port shared by the init walk and training
    // ---------------------------------------------------------------------
    assign up_cnt = pht_mem[up_idx];

    always_comb begin
        up_cnt_next = up_cnt;
        if (up_taken) begin
            if (up_cnt != 2'b11) begin
                up_cnt_next = up_cnt + 2'd1;
            end
        end else if (up_cnt != 2'b00) begin
            up_cnt_next = up_cnt - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (!running) begin
                pht_mem[init_cnt_reg] <= PHT_INIT;
            end else if (up_valid) begin
                pht_mem[up_idx] <= up_cnt_next;
            end
        end
    end

    // ---------------------------------------------------------------------
    // BTB: only taken branches allocate, so not-taken ones never evict
    // ---------------------------------------------------------------------
    assign up_btb_idx = up_pc[BTB_BITS+1:2];
    assign up_tag     = up_pc[DBITS-1:BTB_BITS+2];
    assign btb_wr_en  = running && up_valid && up_taken;

    genvar gi;
    generate
        for (gi = 0; gi < BTB_ENTRIES; gi++) begin : g_btb_valid
            assign btb_clr[gi] = !running && (init_cnt_reg == PHT_BITS'(gi));
            assign btb_set[gi] = btb_wr_en && (up_btb_idx == BTB_BITS'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) begin
            btb_valid_reg <= (btb_valid_reg & ~btb_clr) | btb_set;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && btb_wr_en) begin
            btb_tag_mem[up_btb_idx]    <= up_tag;
            btb_target_mem[up_btb_idx] <= up_target;
        end
    end

endmodule

// File: tb/tb_fe_gshare_bpred.sv
// ---------------------------------------------------------------------------
// tb_fe_gshare_bpred
//   Two predictor instances are exercised side by side:
//     dut 0 - default parameters
//     dut 1 - PHT_BITS=4, HIST_BITS=2, BTB_BITS=2
//   Stimulus pushes hand-computed expectations into a scoreboard queue. A
//   negedge monitor pops them and compares them against the live outputs.
// ---------------------------------------------------------------------------
module tb_fe_gshare_bpred;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // dut 0 signals
    logic        a_reset = 1'b1, a_ready, a_lk_valid = 1'b0, a_pred_taken;
    logic [31:0] a_lk_pc = '0, a_pred_target, a_up_pc = '0, a_up_target = '0;
    logic [7:0]  a_pred_idx, a_pred_hist, a_up_idx = '0, a_up_hist = '0;
    logic        a_up_valid = 1'b0, a_up_taken = 1'b0, a_up_mispred = 1'b0;

    // dut 1 signals
    logic        b_reset = 1'b1, b_ready, b_lk_valid = 1'b0, b_pred_taken;
    logic [31:0] b_lk_pc = '0, b_pred_target, b_up_pc = '0, b_up_target = '0;
    logic [3:0]  b_pred_idx, b_up_idx = '0;
    logic [1:0]  b_pred_hist, b_up_hist = '0;
    logic        b_up_valid = 1'b0, b_up_taken = 1'b0, b_up_mispred = 1'b0;

    fe_gshare_bpred u_dut_a (
        .clk(clk), .reset(a_reset), .ready(a_ready),
        .lk_valid(a_lk_valid), .lk_pc(a_lk_pc),
        .pred_taken(a_pred_taken), .pred_target(a_pred_target),
        .pred_idx(a_pred_idx), .pred_hist(a_pred_hist),
        .up_valid(a_up_valid), .up_taken(a_up_taken), .up_mispred(a_up_mispred),
        .up_pc(a_up_pc), .up_target(a_up_target), .up_idx(a_up_idx), .up_hist(a_up_hist)
    );

    fe_gshare_bpred #(.DBITS(32), .PHT_BITS(4), .HIST_BITS(2), .BTB_BITS(2), .PHT_INIT(2'b01)) u_dut_b (
        .clk(clk), .reset(b_reset), .ready(b_ready),
        .lk_valid(b_lk_valid), .lk_pc(b_lk_pc),
        .pred_taken(b_pred_taken), .pred_target(b_pred_target),
        .pred_idx(b_pred_idx), .pred_hist(b_pred_hist),
        .up_valid(b_up_valid), .up_taken(b_up_taken), .up_mispred(b_up_mispred),
        .up_pc(b_up_pc), .up_target(b_up_target), .up_idx(b_up_idx), .up_hist(b_up_hist)
    );

    typedef struct {
        int          dut;
        string       name;
        bit          ready;
        bit          taken;
        logic [31:0] target;
        bit          chk_hist;
        logic [7:0]  hist;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(string nm, string field, logic [31:0] got, logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s.%s: got %0h expected %0h", nm, field, got, want);
        end
    endtask

    // Monitor: outputs are combinational, so every queued expectation refers
    // to the cycle in which it was pushed.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t        e;
            logic        r, t;
            logic [31:0] tg;
            logic [7:0]  h;
            e = sb.pop_front();
            if (e.dut == 0) begin
                r = a_ready; t = a_pred_taken; tg = a_pred_target; h = a_pred_hist;
            end else begin
                r = b_ready; t = b_pred_taken; tg = b_pred_target; h = {6'b0, b_pred_hist};
            end
            $display("[dut%0d] %s ready=%0d taken=%0d target=%08h hist=%02h", e.dut, e.name, r, t, tg, h);
            chk(e.name, "ready",  {31'b0, r}, {31'b0, e.ready});
            chk(e.name, "taken",  {31'b0, t}, {31'b0, e.taken});
            chk(e.name, "target", tg, e.target);
            if (e.chk_hist) chk(e.name, "hist", {24'b0, h}, {24'b0, e.hist});
        end
    end

    task automatic up(int d, bit t, bit m, logic [31:0] pc, logic [31:0] tgt, logic [7:0] idx, logic [7:0] h);
        if (d == 0) begin
            a_up_valid = 1'b1; a_up_taken = t; a_up_mispred = m;
            a_up_pc = pc; a_up_target = tgt; a_up_idx = idx; a_up_hist = h;
        end else begin
            b_up_valid = 1'b1; b_up_taken = t; b_up_mispred = m;
            b_up_pc = pc; b_up_target = tgt; b_up_idx = idx[3:0]; b_up_hist = h[1:0];
        end
    endtask

    // One cycle: drive lookup, queue the expectation, advance past the edge,
    // then withdraw any training request.
    task automatic step(int d, string nm, bit lv, logic [31:0] pc, bit rdy, bit tk,
                        logic [31:0] tgt, bit chk_h, logic [7:0] h);
        exp_t e;
        if (d == 0) begin a_lk_valid = lv; a_lk_pc = pc; end
        else        begin b_lk_valid = lv; b_lk_pc = pc; end
        e.dut = d; e.name = nm; e.ready = rdy; e.taken = tk;
        e.target = tgt; e.chk_hist = chk_h; e.hist = h;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (d == 0) begin a_up_valid = 1'b0; a_up_taken = 1'b0; a_up_mispred = 1'b0; end
        else        begin b_up_valid = 1'b0; b_up_taken = 1'b0; b_up_mispred = 1'b0; end
    endtask

    task automatic run(int d, string nm, bit lv, logic [31:0] pc, bit tk, logic [31:0] tgt, logic [7:0] h);
        step(d, nm, lv, pc, 1'b1, tk, tgt, 1'b1, h);
    endtask

    task automatic do_reset(int d);
        if (d == 0) a_reset = 1'b1; else b_reset = 1'b1;
        @(posedge clk);
        #1;
        if (d == 0) a_reset = 1'b0; else b_reset = 1'b0;
    endtask

    // n init cycles with ready expected low throughout. With inject set, a
    // few training requests arrive near the end; all must be ignored.
    task automatic init_run(int d, int n, bit inject, logic [31:0] pc, logic [31:0] tgt, logic [7:0] idx);
        for (int k = 1; k <= n; k++) begin
            logic [31:0] lpc;
            lpc = 32'h1000 + 32'(k) * 4;
            if (inject && k == n - 6)                   up(d, 1'b1, 1'b0, pc, tgt, idx, 8'h00);
            else if (inject && k > n - 6 && k <= n - 3) up(d, 1'b0, 1'b0, pc, tgt, idx, 8'h00);
            step(d, "init", 1'b1, lpc, 1'b0, 1'b0, lpc + 32'd4, 1'b0, 8'h00);
        end
    endtask

    task automatic seq_a();
        do_reset(0);
        init_run(0, 256, 1'b1, 32'h100, 32'h200, 8'h40);
        // counter 0x40 = 01, BTB empty, history 0
        up(0, 1, 0, 32'h100, 32'h200, 8'h40, 8'h00); run(0, "a_train_first", 0, 32'h100, 0, 32'h104, 8'h00);
        run(0, "a_pred_taken", 0, 32'h100, 1, 32'h200, 8'h00);
        up(0, 0, 0, 32'h100, 32'h200, 8'h40, 8'h00); run(0, "a_dec1", 0, 32'h100, 1, 32'h200, 8'h00);
        up(0, 0, 0, 32'h100, 32'h200, 8'h40, 8'h00); run(0, "a_dec2", 0, 32'h100, 0, 32'h104, 8'h00);
        up(0, 0, 0, 32'h100, 32'h200, 8'h40, 8'h00); run(0, "a_dec3", 0, 32'h100, 0, 32'h104, 8'h00);
        up(0, 0, 0, 32'h100, 32'h200, 8'h40, 8'h00); run(0, "a_dec4", 0, 32'h100, 0, 32'h104, 8'h00);
        run(0, "a_sat_lo", 0, 32'h100, 0, 32'h104, 8'h00);
        up(0, 1, 0, 32'h100, 32'h200, 8'h40, 8'h00); run(0, "a_inc1", 0, 32'h100, 0, 32'h104, 8'h00);
        up(0, 1, 0, 32'h100, 32'h200, 8'h40, 8'h00); run(0, "a_inc2", 0, 32'h100, 0, 32'h104, 8'h00);
        up(0, 1, 0, 32'h100, 32'h200, 8'h40, 8'h00); run(0, "a_inc3", 0, 32'h100, 1, 32'h200, 8'h00);
        up(0, 1, 0, 32'h100, 32'h200, 8'h40, 8'h00); run(0, "a_inc4", 0, 32'h100, 1, 32'h200, 8'h00);
        up(0, 0, 0, 32'h100, 32'h200, 8'h40, 8'h00); run(0, "a_dec_from3", 0, 32'h100, 1, 32'h200, 8'h00);
        run(0, "a_sat_hi", 0, 32'h100, 1, 32'h200, 8'h00);
        // make the entries reached by histories 1 and 3 predict taken
        up(0, 1, 0, 32'h100, 32'h200, 8'h41, 8'h00); run(0, "a_train41", 0, 32'h100, 1, 32'h200, 8'h00);
        up(0, 1, 0, 32'h100, 32'h200, 8'h43, 8'h00); run(0, "a_train43", 0, 32'h100, 1, 32'h200, 8'h00);
        run(0, "a_spec1", 1, 32'h100, 1, 32'h200, 8'h00);
        run(0, "a_spec2", 1, 32'h100, 1, 32'h200, 8'h01);
        run(0, "a_spec3", 1, 32'h100, 1, 32'h200, 8'h03);
        run(0, "a_hist7", 0, 32'h100, 0, 32'h104, 8'h07);
        up(0, 0, 1, 32'h104, 32'h000, 8'h80, 8'h01); run(0, "a_repair", 0, 32'h100, 0, 32'h104, 8'h07);
        run(0, "a_repaired", 0, 32'h100, 0, 32'h104, 8'h02);
        up(0, 1, 1, 32'h104, 32'h500, 8'h81, 8'h05); run(0, "a_repair_vs_spec", 1, 32'h100, 0, 32'h104, 8'h02);
        run(0, "a_repair_won", 0, 32'h100, 0, 32'h104, 8'h0B);
        run(0, "a_miss_no_shift", 1, 32'h108, 0, 32'h10C, 8'h0B);
        run(0, "a_miss_held", 0, 32'h108, 0, 32'h10C, 8'h0B);
        up(0, 0, 1, 32'h10C, 32'h000, 8'h82, 8'h00); run(0, "a_repair_zero", 0, 32'h100, 0, 32'h104, 8'h0B);
        run(0, "a_hist_zero", 0, 32'h100, 1, 32'h200, 8'h00);
        // BTB aliasing: 0x100, 0x140 and 0x180 share BTB index 0
        up(0, 1, 0, 32'h140, 32'h240, 8'h50, 8'h00); run(0, "a_alias_alloc", 0, 32'h100, 1, 32'h200, 8'h00);
        run(0, "a_alias_miss", 0, 32'h100, 0, 32'h104, 8'h00);
        run(0, "a_alias_hit", 0, 32'h140, 1, 32'h240, 8'h00);
        up(0, 0, 0, 32'h180, 32'h999, 8'h60, 8'h00); run(0, "a_nt_update", 0, 32'h140, 1, 32'h240, 8'h00);
        run(0, "a_nt_no_evict", 0, 32'h140, 1, 32'h240, 8'h00);
        run(0, "a_nt_no_alloc", 0, 32'h180, 0, 32'h184, 8'h00);
        // reset in the middle of RUN
        do_reset(0);
        init_run(0, 256, 1'b0, 32'h0, 32'h0, 8'h00);
        run(0, "a_post_reset_100", 0, 32'h100, 0, 32'h104, 8'h00);
        run(0, "a_post_reset_140", 0, 32'h140, 0, 32'h144, 8'h00);
    endtask

    task automatic seq_b();
        // pc 0x24: PHT index 9, BTB index 1
        do_reset(1);
        init_run(1, 16, 1'b1, 32'h24, 32'h80, 8'h09);
        up(1, 1, 0, 32'h24, 32'h80, 8'h09, 8'h00); run(1, "b_train_first", 0, 32'h24, 0, 32'h28, 8'h00);
        run(1, "b_pred_taken", 0, 32'h24, 1, 32'h80, 8'h00);
        up(1, 0, 0, 32'h24, 32'h80, 8'h09, 8'h00); run(1, "b_dec1", 0, 32'h24, 1, 32'h80, 8'h00);
        up(1, 0, 0, 32'h24, 32'h80, 8'h09, 8'h00); run(1, "b_dec2", 0, 32'h24, 0, 32'h28, 8'h00);
        up(1, 0, 0, 32'h24, 32'h80, 8'h09, 8'h00); run(1, "b_dec3", 0, 32'h24, 0, 32'h28, 8'h00);
        up(1, 0, 0, 32'h24, 32'h80, 8'h09, 8'h00); run(1, "b_dec4", 0, 32'h24, 0, 32'h28, 8'h00);
        run(1, "b_sat_lo", 0, 32'h24, 0, 32'h28, 8'h00);
        up(1, 1, 0, 32'h24, 32'h80, 8'h09, 8'h00); run(1, "b_inc1", 0, 32'h24, 0, 32'h28, 8'h00);
        up(1, 1, 0, 32'h24, 32'h80, 8'h09, 8'h00); run(1, "b_inc2", 0, 32'h24, 0, 32'h28, 8'h00);
        run(1, "b_spec1", 1, 32'h24, 1, 32'h80, 8'h00);
        run(1, "b_spec2", 1, 32'h24, 0, 32'h28, 8'h01);
        run(1, "b_hist2", 0, 32'h24, 0, 32'h28, 8'h02);
        up(1, 1, 1, 32'h24, 32'h80, 8'h0B, 8'h03); run(1, "b_repair_vs_spec", 1, 32'h24, 0, 32'h28, 8'h02);
        run(1, "b_repaired", 0, 32'h24, 0, 32'h28, 8'h03);
    endtask

    task automatic summary();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    endtask

    initial begin
        fork
            seq_a();
            seq_b();
        join
        @(negedge clk);
        #1;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        summary();
        $finish;
    end

    initial begin
        #50000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        summary();
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fe_gshare_bpred.md
# fe_gshare_bpred

Parametrised gshare branch predictor with a direct-mapped BTB, used by the fetch stage to pick the next PC. It generalises the fixed 256-entry PHT / 8-bit history / 16-entry BTB predictor in three ways: every table size is configurable, global history is updated speculatively and repaired on mispredict, and a reset-time init sequencer sets the PHT to a programmable state. Lookup is combinational, in the same cycle as the fetch-PC read. Training arrives from AGEX.

## Interface
- DBITS, 32, address/target width
- PHT_BITS, 8, log2 PHT entries; PC index bits [PHT_BITS+1:2]
- HIST_BITS, 8, global history length; must be ≤ PHT_BITS and ≥ 2
- BTB_BITS, 4, log2 BTB entries; must be ≤ PHT_BITS
- PHT_INIT, 2'b01, 2-bit counter value written to every PHT entry during init
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- ready  out  1  high once init is complete
- lk_valid  in  1  fetch is consuming a prediction this cycle
- lk_pc  in  DBITS  fetch PC
- pred_taken  out  1  predicted taken
- pred_target  out  DBITS  predicted next PC
- pred_idx  out  PHT_BITS  PHT index used; travels down the pipe
- pred_hist  out  HIST_BITS  history snapshot before this lookup; travels down the pipe
- up_valid  in  1  resolved branch from AGEX
- up_taken  in  1  actual direction
- up_mispred  in  1  resolved next PC differs from predicted next PC
- up_pc, up_target  in  DBITS  branch PC and taken target
- up_idx  in  PHT_BITS  pred_idx echoed back
- up_hist  in  HIST_BITS  pred_hist echoed back

## Operation
- **FSM states: INIT, RUN.**
  - Reset forces INIT with init_cnt = 0 and spec_hist = 0.
  - In INIT, each non-reset edge writes PHT[init_cnt] = PHT_INIT. When init_cnt < 2^BTB_BITS, it also clears BTB valid[init_cnt]. init_cnt then increments.
  - The edge that writes entry 2^PHT_BITS−1 moves the FSM to RUN.
  - RUN has no exit except reset. Reset mid-RUN restarts INIT.
- **Outputs during INIT:**
  - ready = 0, pred_taken = 0, pred_target = lk_pc+4.
  - pred_idx and pred_hist are don't-care.
  - up_* and lk_valid are ignored; no state changes except the init writes.
- **Lookup (RUN, combinational):**
  - idx = lk_pc[PHT_BITS+1:2] XOR {zero-extended spec_hist}.
  - BTB entry = BTB[lk_pc[BTB_BITS+1:2]]. hit = valid && tag == lk_pc[DBITS-1:BTB_BITS+2].
  - pred_taken = hit && PHT[idx][1].
  - pred_target = pred_taken ? entry.target : lk_pc+4, computed modulo 2^DBITS.
  - pred_hist = spec_hist.
- **Speculative history (RUN):**
  - If lk_valid && hit: spec_hist <= {spec_hist[HIST_BITS-2:0], pred_taken}.
  - If up_valid && up_mispred: spec_hist <= {up_hist[HIST_BITS-2:0], up_taken}.
  - The repair takes priority over a same-cycle speculative shift.
  - A correctly predicted update leaves spec_hist unchanged.
- **Training (RUN, up_valid):**
  - PHT[up_idx] is a 2-bit saturating counter: increment if taken (stays at 3), decrement if not taken (stays at 0).
  - BTB write happens only when up_taken: BTB[up_pc[BTB_BITS+1:2]] <= {1, up_pc tag, up_target}. Not-taken branches never allocate or evict.

## Timing
- Lookup has zero latency: outputs depend on lk_pc and the current table/register state.
- All state updates occur at the rising edge.
- ready rises after exactly 2^PHT_BITS non-reset edges following reset deassertion. This is 256 cycles at the defaults.
- **Same-cycle update and lookup to the same PHT or BTB entry:** the lookup sees the pre-update value. The new value is visible from the next cycle.
- **Reset values:**
  - ready = 0 and spec_hist = 0.
  - pred_taken = 0 and pred_target = lk_pc+4.
  - BTB valid bits are considered clear from the first INIT cycle, because pred_taken is forced to 0 during INIT.
- No stall input: fetch holds lk_valid low while stalled, which also holds history.

## Test plan
- **Init:** pulse reset for 1 cycle, then count. ready = 0 for 256 cycles and 1 on cycle 257. Any lk_pc gives pred_taken = 0 and pred_target = pc+4. An up_valid during INIT must not alter the PHT; check by reading the entry after ready.
- **Training to taken:** with defaults, send up_valid/up_taken/up_mispred for pc 0x100, target 0x200, idx 0x40, hist 0. The first update moves the counter 01→10 and allocates the BTB entry. With spec_hist = 0, lk_pc = 0x100 then gives pred_taken = 1 and pred_target = 0x200. Four not-taken updates saturate the counter at 0 and the prediction returns to 0x104.
- **Speculative history and repair:**
  - Three lookups that hit and predict taken give spec_hist = 0x07.
  - Then send up_mispred with up_hist = 0x01 and up_taken = 0; next cycle spec_hist = 0x02.
  - With lk_valid and a hit on the same cycle as the repair, the repair wins.
- **BTB aliasing:** a taken update at 0x100 followed by a taken update at 0x140 (same BTB index, different tag). A lookup of 0x100 then misses and returns pc+4 with pred_taken = 0. A not-taken update at 0x180 must not evict the entry.
- **Reset mid-RUN:** after training, assert reset for 1 cycle. ready drops, spec_hist = 0, and after re-init a lookup of 0x100 predicts 0x104.
- **Parameter sweep:** repeat the init and training tests with PHT_BITS = 4, HIST_BITS = 2, BTB_BITS = 2. ready must rise after 16 cycles.
